// File: rtl/circ_rotate_pkg.sv
// Shared types and helpers for the pipelined circular right rotator.
// The record width is fixed by CIRC_N here. To build a different width,
// change CIRC_N, which must be a power of two and at least 2.
package circ_rotate_pkg;

    localparam int CIRC_N = 8;
    localparam int CIRC_W = $clog2(CIRC_N);

    typedef logic [CIRC_N-1:0] word_t;
    typedef logic [CIRC_W-1:0] amt_t;

    // One pipeline register. The full amount travels with the word,
    // and stage k consumes only bit k of it.
    typedef struct packed {
        logic  valid;
        word_t data;
        amt_t  amt;
    } stage_t;

    // Rotate right by 2^k. This is equivalent to {d[2^k-1:0], d[N-1:2^k]}.
    // The index wraps naturally in CIRC_W bits, so the result is pure
    // rewiring when k is a constant.
    function automatic word_t rotr_slice(input word_t d, input int k);
        word_t r;
        amt_t  idx;
        r = '0;
        for (int i = 0; i < CIRC_N; i++) begin
            idx  = amt_t'(i + (1 << k));
            r[i] = d[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/circ_rotate_stage.sv
// One barrel stage. It rotates right by 2^K when amount bit K is set.
// When adv is high it loads from upstream; otherwise it holds its contents.
module circ_rotate_stage
    import circ_rotate_pkg::*;
#(
    parameter int K = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   adv,
    input  stage_t up,
    output stage_t q
);

    // Register stage: on adv, load the upstream record, conditionally rotated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (adv) begin
            q.valid <= up.valid;
            q.data  <= up.amt[K] ? rotr_slice(up.data, K) : up.data;
            q.amt   <= up.amt;
        end
    end

endmodule

// File: rtl/circular_rotate_right_pipe.sv
// Pipelined variable-amount circular right rotator with a valid/ready
// handshake on both sides. It has one register stage per amount bit, so
// latency is W cycles and throughput is one word per clock. Bubbles collapse:
// a stage advances whenever it is empty or its successor advances.
// Optional macro CIRC_ROTATE_LEFT_DIR_EN adds the in_dir port
// (0 = right, 1 = left). A left rotation by a is converted at entry into a
// right rotation by (N - a) mod N.
module circular_rotate_right_pipe
    import circ_rotate_pkg::*;
#(
    parameter  int N = CIRC_N,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [W-1:0] in_amt,
`ifdef CIRC_ROTATE_LEFT_DIR_EN
    input  logic         in_dir,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    stage_t         st_in;
    stage_t         st [W];
    logic   [W-1:0] stage_valid;
    logic   [W-1:0] adv;
    amt_t           amt_eff;
    logic           adv_acc;
    logic           unused_amt;

`ifdef CIRC_ROTATE_LEFT_DIR_EN
    // Left by a equals right by -a mod N. Two's complement in W bits gives that wrap.
    assign amt_eff = in_dir ? amt_t'(~in_amt + amt_t'(1)) : in_amt;
`else
    assign amt_eff = in_amt;
`endif

    // Stage-0 entry record. It is valid only on an actual input transfer.
    always_comb begin
        st_in.valid = in_valid && in_ready;
        st_in.data  = in_data;
        st_in.amt   = amt_eff;
    end

    // Advance chain, evaluated from the output end back toward the input.
    always_comb begin
        adv     = '0;
        adv_acc = !stage_valid[W-1] || out_ready;
        for (int k = W - 1; k >= 0; k--) begin
            adv_acc = !stage_valid[k] || adv_acc;
            adv[k]  = adv_acc;
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_stage
        if (k == 0) begin : g_first
            circ_rotate_stage #(.K(k)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .adv   (adv[k]),
                .up    (st_in),
                .q     (st[k])
            );
        end else begin : g_rest
            circ_rotate_stage #(.K(k)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .adv   (adv[k]),
                .up    (st[k-1]),
                .q     (st[k])
            );
        end
        assign stage_valid[k] = st[k].valid;
    end

    assign in_ready   = adv[0];
    assign out_valid  = st[W-1].valid;
    assign out_data   = st[W-1].data;
    assign unused_amt = ^st[W-1].amt;

endmodule

// File: tb/tb_circular_rotate_right_pipe.sv
// Directed and table-driven bench for circular_rotate_right_pipe (N=8).
// Inputs change 1 ns after the rising edge. Outputs are sampled 1 ns later,
// which is well before the next edge.
module tb_circular_rotate_right_pipe;

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic       dir;
        logic [7:0] expv;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef CIRC_ROTATE_LEFT_DIR_EN
    logic       in_dir;
`endif

    logic [7:0] exp_q[$];
    vec_t       vecs[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         n_in    = 0;
    int         n_out   = 0;

    always #5 clk = ~clk;

    circular_rotate_right_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
`ifdef CIRC_ROTATE_LEFT_DIR_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic dir);
        logic [2:0]  s;
        logic [15:0] t;
        s = dir ? 3'(3'd0 - a) : a;
        t = {d, d} >> s;
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // One handshake cycle with scoreboard bookkeeping.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] a,
                         input logic r, input logic [7:0] expv);
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        out_ready = r;
        #1;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got output %0h expected none", out_data);
            end else begin
                chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (in_valid && in_ready) begin
            n_in++;
            exp_q.push_back(expv);
        end
        @(posedge clk); #1;
    endtask

    // Presents a single word to an empty pipe and checks for exactly one
    // out_valid pulse, three cycles later.
    task automatic latency_probe(input string name, input logic [7:0] d,
                                 input logic [2:0] a, input logic [7:0] expv);
`ifdef CIRC_ROTATE_LEFT_DIR_EN
        in_dir = 1'b0;
`endif
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk({name, "_out_valid"}, {31'd0, out_valid}, {31'd0, (c == 3)});
            if (c == 3) chk({name, "_out_data"}, {24'd0, out_data}, {24'd0, expv});
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] bb_exp [3];
        logic [7:0] held;
        logic [7:0] rd;
        logic [2:0] ra;
        logic       rdir;
        int         n0;
        int         budget;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;
`ifdef CIRC_ROTATE_LEFT_DIR_EN
        in_dir    = 1'b0;
`endif

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word: latency 3, one-cycle pulse
        latency_probe("lat_b5_r3", 8'b10110101, 3'd3, 8'b10110110);

        // Back-to-back words with amounts 0, 1, 7
        bb_exp = '{8'b00000001, 8'b10000000, 8'b00000010};
        for (int c = 0; c < 7; c++) begin
            in_valid  = (c < 3);
            in_data   = 8'b00000001;
            in_amt    = (c == 0) ? 3'd0 : (c == 1) ? 3'd1 : 3'd7;
            out_ready = 1'b1;
            #1;
            if (c < 3) chk("bb_in_ready", {31'd0, in_ready}, 32'd1);
            chk("bb_out_valid", {31'd0, out_valid}, {31'd0, (c >= 3 && c <= 5)});
            if (c >= 3 && c <= 5) chk("bb_out_data", {24'd0, out_data}, {24'd0, bb_exp[c-3]});
            @(posedge clk); #1;
        end

        // Table of directed vectors, streamed back to back
        vecs.push_back('{8'hB5, 3'd3, 1'b0, 8'hB6});
        vecs.push_back('{8'h01, 3'd0, 1'b0, 8'h01});
        vecs.push_back('{8'h01, 3'd1, 1'b0, 8'h80});
        vecs.push_back('{8'h01, 3'd7, 1'b0, 8'h02});
        vecs.push_back('{8'hF0, 3'd3, 1'b0, 8'h1E});
        vecs.push_back('{8'h80, 3'd7, 1'b0, 8'h01});
        vecs.push_back('{8'hA5, 3'd4, 1'b0, 8'h5A});
        vecs.push_back('{8'h3C, 3'd2, 1'b0, 8'h0F});
        vecs.push_back('{8'h01, 3'd4, 1'b0, 8'h10});
        vecs.push_back('{8'hFF, 3'd5, 1'b0, 8'hFF});
        vecs.push_back('{8'hC3, 3'd6, 1'b0, 8'h0F});
`ifdef CIRC_ROTATE_LEFT_DIR_EN
        vecs.push_back('{8'hB5, 3'd3, 1'b1, 8'hAD});
        vecs.push_back('{8'hB5, 3'd0, 1'b1, 8'hB5});
        vecs.push_back('{8'h01, 3'd1, 1'b1, 8'h02});
        vecs.push_back('{8'h80, 3'd7, 1'b1, 8'h40});
`endif
        n0 = n_out;
        foreach (vecs[i]) begin
`ifdef CIRC_ROTATE_LEFT_DIR_EN
            in_dir = vecs[i].dir;
`endif
            cycle(1'b1, vecs[i].data, vecs[i].amt, 1'b1, vecs[i].expv);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'h00);
        chk("tbl_count", n_out - n0, vecs.size());
        chk("tbl_drained", exp_q.size(), 32'd0);
`ifdef CIRC_ROTATE_LEFT_DIR_EN
        in_dir = 1'b0;
`endif

        // Backpressure: fill with three words, stall five cycles, release
        n0 = n_out;
        cycle(1'b1, 8'h12, 3'd1, 1'b0, 8'h09);
        cycle(1'b1, 8'h34, 3'd2, 1'b0, 8'h0D);
        cycle(1'b1, 8'h56, 3'd3, 1'b0, 8'hCA);
        held = 8'h09;
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            in_data   = 8'h78;
            in_amt    = 3'd4;
            out_ready = 1'b0;
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data_stable", {24'd0, out_data}, {24'd0, held});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("full_simul_in_ready", {31'd0, in_ready}, 32'd1);
        cycle(1'b1, 8'h78, 3'd4, 1'b1, 8'h87);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'h00);
        chk("bp_count", n_out - n0, 32'd4);
        chk("bp_drained", exp_q.size(), 32'd0);

        // Reset with two words in flight
        cycle(1'b1, 8'hAA, 3'd1, 1'b1, 8'h55);
        cycle(1'b1, 8'hCC, 3'd2, 1'b1, 8'h33);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data",  {24'd0, out_data},  32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        latency_probe("post_rst_f0_r3", 8'b11110000, 3'd3, 8'b00011110);

        // Random stream with random backpressure, checked against {a,a}>>amt
        n0     = n_in;
        budget = 0;
        while ((n_in - n0) < 1000 && budget < 20000) begin
            rd   = 8'($urandom);
            ra   = 3'($urandom_range(0, 7));
`ifdef CIRC_ROTATE_LEFT_DIR_EN
            rdir   = 1'($urandom_range(0, 1));
            in_dir = rdir;
`else
            rdir = 1'b0;
`endif
            cycle(($urandom_range(0, 3) != 0), rd, ra, ($urandom_range(0, 3) != 0),
                  model(rd, ra, rdir));
            budget++;
        end
        chk("rand_sent", n_in - n0, 32'd1000);
`ifdef CIRC_ROTATE_LEFT_DIR_EN
        in_dir = 1'b0;
`endif
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'h00);
            budget++;
        end
        chk("rand_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
